// File: rtl/loadarch_pkg.sv
// Shared definitions for the architectural-state load sequencer:
// write kinds, schedule boundaries and the CSR address table.
package loadarch_pkg;

  typedef enum logic [1:0] {
    KIND_CSR = 2'd0,
    KIND_FPR = 2'd1,
    KIND_XPR = 2'd2,
    KIND_PC  = 2'd3
  } wr_kind_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WR,
    S_HOLD,
    S_DONE
  } seq_state_e;

  localparam int ENTRY_W     = 7;
  localparam int NUM_CSR     = 24;
  localparam int NUM_ENTRIES = 88;
  // Schedule boundaries: CSRs [0,24), FPRs [24,56), XPR1..31 [56,87), PC 87.
  localparam int FPR_BASE    = 24;
  localparam int XPR_BASE    = 56;
  localparam int PC_ENTRY    = 87;

  // CSR address for schedule entry i (0..NUM_CSR-1), in load order.
  function automatic logic [11:0] csr_addr(input logic [4:0] i);
    logic [11:0] a;
    case (i)
      5'd0:    a = 12'h105; // stvec
      5'd1:    a = 12'h140; // sscratch
      5'd2:    a = 12'h141; // sepc
      5'd3:    a = 12'h142; // scause
      5'd4:    a = 12'h143; // stval
      5'd5:    a = 12'h180; // satp
      5'd6:    a = 12'h300; // mstatus
      5'd7:    a = 12'h302; // medeleg
      5'd8:    a = 12'h303; // mideleg
      5'd9:    a = 12'h304; // mie
      5'd10:   a = 12'h305; // mtvec
      5'd11:   a = 12'h340; // mscratch
      5'd12:   a = 12'h341; // mepc
      5'd13:   a = 12'h342; // mcause
      5'd14:   a = 12'h343; // mtval
      5'd15:   a = 12'h344; // mip
      5'd16:   a = 12'hB00; // mcycle
      5'd17:   a = 12'hB02; // minstret
      5'd18:   a = 12'h003; // fcsr
      5'd19:   a = 12'h008; // vstart
      5'd20:   a = 12'h009; // vxsat
      5'd21:   a = 12'h00A; // vxrm
      5'd22:   a = 12'h00F; // vcsr
      5'd23:   a = 12'hC21; // vtype
      default: a = 12'h000;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/loadarch_entry_decode.sv
// Maps a schedule entry index to the kind and index of the core state it writes.
module loadarch_entry_decode
  import loadarch_pkg::*;
(
  input  logic [ENTRY_W-1:0] i_entry,
  output wr_kind_e           o_kind,
  output logic [11:0]        o_idx
);

  // Region lookup: CSR table, FPR number, XPR number (x1 first), or PC.
  always_comb begin
    o_kind = KIND_PC;
    o_idx  = 12'd0;
    if (i_entry < 7'(FPR_BASE)) begin
      o_kind = KIND_CSR;
      o_idx  = csr_addr(i_entry[4:0]);
    end else if (i_entry < 7'(XPR_BASE)) begin
      o_kind = KIND_FPR;
      o_idx  = 12'(i_entry - 7'(FPR_BASE));
    end else if (i_entry < 7'(PC_ENTRY)) begin
      o_kind = KIND_XPR;
      o_idx  = 12'(i_entry - 7'(XPR_BASE - 1));
    end
  end

endmodule

// File: rtl/loadarch_sequencer.sv
// Loads an architectural-state image into a held-in-reset core: reads each
// schedule entry from memory, writes it to the core, then releases the core
// after a fixed delay.
module loadarch_sequencer
  import loadarch_pkg::*;
#(
  parameter int RELEASE_DELAY = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                fp_en,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ENTRY_W-1:0]  mem_req_addr,
  input  logic                mem_resp_valid,
  input  logic [63:0]         mem_resp_data,
  output logic                wr_valid,
  input  logic                wr_ready,
  output logic [1:0]          wr_kind,
  output logic [11:0]         wr_idx,
  output logic [63:0]         wr_data,
  output logic                core_reset_hold,
  output logic                busy,
  output logic                done
);

  seq_state_e         r_state;
  seq_state_e         w_state_nx;
  logic [ENTRY_W-1:0] r_entry;
  logic [ENTRY_W-1:0] w_entry_nx;
  logic               r_fp_en;
  logic [7:0]         r_hold_cnt;
  logic [63:0]        r_wr_data;
  logic               w_start_acc;
  logic               w_wr_acc;
  logic               w_last_entry;
  wr_kind_e           w_kind;
  logic [11:0]        w_idx;

  loadarch_entry_decode u_decode (
    .i_entry (r_entry),
    .o_kind  (w_kind),
    .o_idx   (w_idx)
  );

  assign w_start_acc  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_wr_acc     = (r_state == S_WR) && wr_ready;
  assign w_last_entry = (r_entry == 7'(PC_ENTRY));
  // Without FP state the FPR block is skipped straight to x1.
  assign w_entry_nx   = ((r_entry == 7'(NUM_CSR - 1)) && !r_fp_en) ? 7'(XPR_BASE)
                                                                   : r_entry + 7'd1;

  // Control state: FSM state, schedule pointer, FP mode and release counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_entry    <= '0;
      r_fp_en    <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_start_acc) begin
        r_entry <= '0;
        r_fp_en <= fp_en;
      end else if (w_wr_acc) begin
        if (w_last_entry) r_hold_cnt <= 8'(RELEASE_DELAY);
        else              r_entry    <= w_entry_nx;
      end else if ((r_state == S_HOLD) && (r_hold_cnt != 8'd0)) begin
        r_hold_cnt <= r_hold_cnt - 8'd1;
      end
    end
  end

  // Image word captured only while a read is outstanding; stale responses drop.
  always_ff @(posedge clock) begin
    if ((r_state == S_WAIT) && mem_resp_valid) r_wr_data <= mem_resp_data;
  end

  // Next-state and handshake/status outputs decoded from the current state.
  always_comb begin
    w_state_nx      = r_state;
    mem_req_valid   = 1'b0;
    wr_valid        = 1'b0;
    busy            = 1'b1;
    done            = 1'b0;
    core_reset_hold = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nx = S_REQ;
      end
      S_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) w_state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (mem_resp_valid) w_state_nx = S_WR;
      end
      S_WR: begin
        wr_valid = 1'b1;
        if (wr_ready) w_state_nx = w_last_entry ? S_HOLD : S_REQ;
      end
      S_HOLD: begin
        if (r_hold_cnt == 8'd0) w_state_nx = S_DONE;
      end
      S_DONE: begin
        busy            = 1'b0;
        done            = 1'b1;
        core_reset_hold = 1'b0;
        if (start) w_state_nx = S_REQ;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign mem_req_addr = r_entry;
  assign wr_kind      = w_kind;
  assign wr_idx       = w_idx;
  assign wr_data      = r_wr_data;

endmodule
